// File: rtl/hazard_pkg.sv
// Shared types for the EXE-stage hazard / forwarding controller.
//   fwd_sel_t  : operand forward source (regfile, MEM, WB)
//   reg_cls_t  : register class encoding (integer, float)
//   hz_state_t : multicycle-stall FSM states
//   clsWidth() : width of a register-class field for a given class count
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        CLS_INT = 1'b0,
        CLS_FP  = 1'b1
    } reg_cls_t;

    typedef enum logic {
        IDLE,
        FP_BUSY
    } hz_state_t;

    // A single-class pipeline still carries a 1-bit class field.
    function automatic int unsigned clsWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller.
//   master : pipeline datapath (drives EXE/MEM/WB info, consumes controls/operands)
//   slave  : hazard_ctrl
// Inputs : EXE sources/classes, validE, multiE, redirectE, MEM/WB destination info,
//          operand candidates RD1E/RD2E/ALUResultM/WD3W.
// Outputs: SrcAE/WriteDataE, forwardAE/BE, stallF/D/E, bubbleM, flushD/E, fpDoneE.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NCLS   = 2
);
    localparam int unsigned CW = clsWidth(NCLS);

    logic [REG_AW-1:0] Rs1E, Rs2E;
    logic [CW-1:0]     Rs1ClsE, Rs2ClsE;
    logic              validE, multiE, redirectE;
    logic [REG_AW-1:0] RdM, RdW;
    logic [CW-1:0]     RdClsM, RdClsW;
    logic              RegWriteM, isLoadM, RegWriteW;
    logic [XLEN-1:0]   RD1E, RD2E, ALUResultM, WD3W;

    logic [XLEN-1:0]   SrcAE, WriteDataE;
    logic [1:0]        forwardAE, forwardBE;
    logic              stallF, stallD, stallE, bubbleM;
    logic              flushD, flushE, fpDoneE;

    modport master (
        output Rs1E, Rs2E, Rs1ClsE, Rs2ClsE, validE, multiE, redirectE,
               RdM, RdClsM, RegWriteM, isLoadM, RdW, RdClsW, RegWriteW,
               RD1E, RD2E, ALUResultM, WD3W,
        input  SrcAE, WriteDataE, forwardAE, forwardBE,
               stallF, stallD, stallE, bubbleM, flushD, flushE, fpDoneE
    );

    modport slave (
        input  Rs1E, Rs2E, Rs1ClsE, Rs2ClsE, validE, multiE, redirectE,
               RdM, RdClsM, RegWriteM, isLoadM, RdW, RdClsW, RegWriteW,
               RD1E, RD2E, ALUResultM, WD3W,
        output SrcAE, WriteDataE, forwardAE, forwardBE,
               stallF, stallD, stallE, bubbleM, flushD, flushE, fpDoneE
    );

endinterface

// File: rtl/hazard_ctrl_operand_hold.sv
// operand_hold: 3:1 forward mux for one EXE operand plus a capture register
// that freezes the resolved value across a stall window.
//   clk, rst   : clock, async active-low reset
//   sel        : forward source
//   rfVal/memVal/wbVal : candidates
//   capture    : stall cycle in which this operand is not waiting on a load
//   clear      : EXE advances or is flushed
//   operand    : held value while holdValid, else live mux output
//   holdValid  : capture register owns the operand
module operand_hold
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  fwd_sel_t        sel,
    input  logic [XLEN-1:0] rfVal,
    input  logic [XLEN-1:0] memVal,
    input  logic [XLEN-1:0] wbVal,
    input  logic            capture,
    input  logic            clear,
    output logic [XLEN-1:0] operand,
    output logic            holdValid
);
    logic [XLEN-1:0] muxOut;
    logic [XLEN-1:0] held;

    always_comb begin
        muxOut = rfVal;
        unique case (sel)
            FWD_MEM: muxOut = memVal;
            FWD_WB:  muxOut = wbVal;
            default: muxOut = rfVal;
        endcase
    end

    // Only the first eligible stall cycle captures; later stall cycles keep
    // it, since MEM/WB have moved on by then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdValid <= 1'b0;
            held      <= '0;
        end else if (clear) begin
            holdValid <= 1'b0;
        end else if (capture && !holdValid) begin
            holdValid <= 1'b1;
            held      <= muxOut;
        end
    end

    assign operand = holdValid ? held : muxOut;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EXE-side forwarding, load-use / multicycle-FP stall, redirect
// flush and operand-hold controller.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : hazard_ctrl_if.slave (pipeline info in, controls and operands out)
// Parameters: XLEN, REG_AW, NCLS (class 0 = integer, x0 hardwired), FP_LAT.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NCLS   = 2,
    parameter int unsigned FP_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned CW   = clsWidth(NCLS);
    localparam int unsigned CNTW = $clog2(FP_LAT) + 1;
    localparam logic [CNTW-1:0] CNT_START = CNTW'((FP_LAT > 1) ? FP_LAT - 2 : 0);

    function automatic logic regMatch(input logic              we,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [CW-1:0]     rdCls,
                                      input logic [REG_AW-1:0] rs,
                                      input logic [CW-1:0]     rsCls);
        return we && (rd == rs) && (rdCls == rsCls) &&
               !((rsCls == CW'(CLS_INT)) && (rs == '0));
    endfunction

    logic      memA, memB, wbA, wbB, loadUse;
    fwd_sel_t  selA, selB;
    hz_state_t state, nextState;
    logic [CNTW-1:0] cnt, nextCnt;
    logic      fpStall, fpDone, stall, flush;
    logic      holdValidA, holdValidB;

    assign memA = regMatch(bus.RegWriteM, bus.RdM, bus.RdClsM, bus.Rs1E, bus.Rs1ClsE);
    assign memB = regMatch(bus.RegWriteM, bus.RdM, bus.RdClsM, bus.Rs2E, bus.Rs2ClsE);
    assign wbA  = regMatch(bus.RegWriteW, bus.RdW, bus.RdClsW, bus.Rs1E, bus.Rs1ClsE);
    assign wbB  = regMatch(bus.RegWriteW, bus.RdW, bus.RdClsW, bus.Rs2E, bus.Rs2ClsE);

    assign selA = (memA && !bus.isLoadM) ? FWD_MEM : (wbA ? FWD_WB : FWD_RF);
    assign selB = (memB && !bus.isLoadM) ? FWD_MEM : (wbB ? FWD_WB : FWD_RF);

    assign loadUse = bus.isLoadM && (memA || memB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // The first FP stall cycle is spent in IDLE, so FP_BUSY counts down the
    // remaining FP_LAT-2 stall cycles and then spends one cycle releasing.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        fpStall   = 1'b0;
        fpDone    = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (!loadUse && bus.validE && bus.multiE) begin
                        if (FP_LAT > 1) begin
                            fpStall   = 1'b1;
                            nextCnt   = CNT_START;
                            nextState = FP_BUSY;
                        end else begin
                            fpDone = 1'b1;
                        end
                    end
                end
                FP_BUSY: begin
                    if (cnt != '0) begin
                        fpStall = 1'b1;
                        nextCnt = cnt - 1'b1;
                    end else begin
                        fpDone    = 1'b1;
                        nextState = IDLE;
                    end
                end
            endcase
        end
    end

    assign stall = rst && (loadUse || fpStall);
    assign flush = rst && bus.redirectE && !stall;

    assign bus.stallF  = stall;
    assign bus.stallD  = stall;
    assign bus.stallE  = stall;
    assign bus.bubbleM = stall;
    assign bus.flushD  = flush;
    assign bus.flushE  = flush;
    assign bus.fpDoneE = fpDone;

    operand_hold #(.XLEN(XLEN)) holdA (
        .clk       (clk),
        .rst       (rst),
        .sel       (selA),
        .rfVal     (bus.RD1E),
        .memVal    (bus.ALUResultM),
        .wbVal     (bus.WD3W),
        .capture   (stall && !(bus.isLoadM && memA)),
        .clear     (!stall || flush),
        .operand   (bus.SrcAE),
        .holdValid (holdValidA)
    );

    operand_hold #(.XLEN(XLEN)) holdB (
        .clk       (clk),
        .rst       (rst),
        .sel       (selB),
        .rfVal     (bus.RD2E),
        .memVal    (bus.ALUResultM),
        .wbVal     (bus.WD3W),
        .capture   (stall && !(bus.isLoadM && memB)),
        .clear     (!stall || flush),
        .operand   (bus.WriteDataE),
        .holdValid (holdValidB)
    );

    assign bus.forwardAE = holdValidA ? FWD_RF : selA;
    assign bus.forwardBE = holdValidB ? FWD_RF : selB;

endmodule
